// File: rtl/gpio_pkg.sv
// Shared register map for the memory-mapped GPIO block: default window base,
// register offsets and the bus address decoder used by mmio_gpio.
package gpio_pkg;

    localparam logic [15:0] GPIO_BASE_ADDR = 16'hC000;

    localparam logic [1:0] OUT_OFS  = 2'd0;
    localparam logic [1:0] IN_OFS   = 2'd1;
    localparam logic [1:0] EDGE_OFS = 2'd2;
    localparam logic [1:0] MASK_OFS = 2'd3;

    // Result of decoding one bus address against the four-register window.
    typedef struct packed {
        logic       hit;
        logic [1:0] ofs;
    } reg_dec_t;

    // The subtraction wraps modulo 2^16, so a window placed at the top of
    // the address space still decodes correctly.
    function automatic reg_dec_t decode_addr(input logic [15:0] addr,
                                             input logic [15:0] base);
        logic [15:0] delta;
        reg_dec_t    res;
        delta   = addr - base;
        res.hit = (delta[15:2] == 14'd0);
        res.ofs = delta[1:0];
        return res;
    endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// Conditioning for one asynchronous GPIO input bit: a two-flop synchronizer,
// an optional debouncer (compiled in when GPIO_DEBOUNCE_EN is defined) and a
// rising-edge detector. A level only counts as a real sample once it has come
// out of the synchronizer (and, with debounce, out of the debouncer), so the
// reset values of these flops can never produce a false rising edge.
module gpio_in_cond #(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1_q, sync2_q;
    logic vld1_q, vld2_q;
    logic level, level_vld;
    logic prev_q, prev_vld_q;

    // Synchronize the pin and track when the synchronizer holds a real sample.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    // A limit of zero would never be reached; treat it as "no filtering".
    localparam logic [15:0] DB_LIMIT = (DB_CYCLES == 16'd0) ? 16'd1 : DB_CYCLES;

    logic [15:0] cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        db_q, db_d;
    logic        db_vld_q, db_vld_d;

    // Count the length of the current run of identical samples; commit the
    // sample to the debounced output once the run reaches DB_LIMIT.
    // NOTE: every variable gets its hold value first so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d    = cnt_q;
        run_d    = run_q;
        db_d     = db_q;
        db_vld_d = db_vld_q;
        if (vld2_q) begin
            run_d = sync2_q;
            if ((cnt_q != 16'd0) && (sync2_q == run_q)) begin
                if (cnt_q != DB_LIMIT) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end else begin
                cnt_d = 16'd1;
            end
            if (cnt_d == DB_LIMIT) begin
                db_d     = sync2_q;
                db_vld_d = 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 16'd0;
            run_q    <= 1'b0;
            db_q     <= 1'b0;
            db_vld_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            db_q     <= db_d;
            db_vld_q <= db_vld_d;
        end
    end

    assign level     = db_q;
    assign level_vld = db_vld_q;
`else
    assign level     = sync2_q;
    assign level_vld = vld2_q;
`endif

    // Remember the previous conditioned level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= 1'b0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= level;
            prev_vld_q <= level_vld;
        end
    end

    // A rise needs two consecutive real samples, the older one being 0.
    assign rise_o  = level_vld & prev_vld_q & level & ~prev_q;
    assign level_o = level;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO peripheral: four registers (OUT, IN, EDGE, MASK) in a
// window at BASE_ADDR, sticky write-one-to-clear rising-edge flags and a
// level interrupt. Define GPIO_DEBOUNCE_EN to add per-bit input debouncing
// with a stability count of DB_CYCLES.
module mmio_gpio
    import gpio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = GPIO_BASE_ADDR,
    parameter int unsigned OUT_W     = 10,
    parameter int unsigned IN_W      = 10,
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr,
    input  logic [15:0]       wdata,
    input  logic              we,
    input  logic              re,
    output logic [15:0]       rdata,
    input  logic [IN_W-1:0]   gpio_in,
    output logic [OUT_W-1:0]  gpio_out,
    output logic              irq
);

    reg_dec_t         dec;
    logic             wr_out, wr_edge, wr_mask;
    logic [IN_W-1:0]  in_level, in_rise, edge_clr;
    logic [OUT_W-1:0] out_q, out_d;
    logic [IN_W-1:0]  mask_q, mask_d;
    logic [IN_W-1:0]  edge_q, edge_d;
    logic             unused_wdata;

    assign dec     = decode_addr(addr, BASE_ADDR);
    assign wr_out  = we & dec.hit & (dec.ofs == OUT_OFS);
    assign wr_edge = we & dec.hit & (dec.ofs == EDGE_OFS);
    assign wr_mask = we & dec.hit & (dec.ofs == MASK_OFS);

    // Data bits above the register widths are intentionally dropped.
    assign unused_wdata = ^wdata;

    for (genvar i = 0; i < IN_W; i++) begin : g_in
        gpio_in_cond #(
            .DB_CYCLES(DB_CYCLES)
        ) u_cond (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin_i  (gpio_in[i]),
            .level_o(in_level[i]),
            .rise_o (in_rise[i])
        );
    end

    assign edge_clr = {IN_W{wr_edge}} & wdata[IN_W-1:0];

    // Next-state for the writable registers; a rising edge wins over a W1C.
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        if (wr_out) begin
            out_d = wdata[OUT_W-1:0];
        end
        if (wr_mask) begin
            mask_d = wdata[IN_W-1:0];
        end
        edge_d = (edge_q & ~edge_clr) | in_rise;
    end

    // Register file state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            mask_q <= '0;
            edge_q <= '0;
        end else begin
            out_q  <= out_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
        end
    end

    // Read mux: zero-extended register value while re hits the window.
    always_comb begin
        rdata = 16'h0000;
        if (re && dec.hit) begin
            case (dec.ofs)
                OUT_OFS:  rdata = 16'(out_q);
                IN_OFS:   rdata = 16'(in_level);
                EDGE_OFS: rdata = 16'(edge_q);
                MASK_OFS: rdata = 16'(mask_q);
                default:  rdata = 16'h0000;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_mmio_gpio.sv
// Self-checking bench for mmio_gpio: directed register-map scenarios followed
// by randomized bus traffic and pin activity, all compared with a reference
// model that derives IN/EDGE from the history of applied pin values.
// Works in the default build and with GPIO_DEBOUNCE_EN defined.
module tb_mmio_gpio;

    localparam logic [15:0] BASE = 16'hC000;
    localparam int          W    = 10;
`ifdef GPIO_DEBOUNCE_EN
    localparam int          DB   = 8;
    localparam logic [15:0] TB_DB_CYCLES = 16'd8;
`else
    localparam int          DB   = 0;
    localparam logic [15:0] TB_DB_CYCLES = 16'd50000;
`endif

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b1;
    logic [15:0]  addr    = 16'h0;
    logic [15:0]  wdata   = 16'h0;
    logic         we      = 1'b0;
    logic         re      = 1'b0;
    logic [15:0]  rdata;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] gpio_out;
    logic         irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_gpio #(
        .BASE_ADDR(BASE),
        .OUT_W    (W),
        .IN_W     (W),
        .DB_CYCLES(TB_DB_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .irq     (irq)
    );

    // Reference model: pins[e] is the pin value present before clock edge e
    // (counted from reset release), lvl[e]/vld[e] the conditioned input
    // level after edge e and whether that level is a real sample.
    int           n;
    logic [W-1:0] pins[$];
    logic [W-1:0] lvl[$];
    logic [W-1:0] vld[$];
    logic [W-1:0] out_m, mask_m, edge_m;
    logic [W-1:0] cur_pin = '0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        pins.delete(); pins.push_back('0);
        lvl.delete();  lvl.push_back('0);
        vld.delete();  vld.push_back('0);
        out_m  = '0;
        mask_m = '0;
        edge_m = '0;
    endtask

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        logic [15:0] ofs;
        ofs = a - BASE;
        case (ofs)
            16'd0:   return 16'(out_m);
            16'd1:   return 16'(lvl[n]);
            16'd2:   return 16'(edge_m);
            16'd3:   return 16'(mask_m);
            default: return 16'h0000;
        endcase
    endfunction

    // Advance the model across one rising clock edge.
    task automatic model_edge(input logic w, input logic [15:0] a, input logic [15:0] d,
                              input logic [W-1:0] p);
        logic [W-1:0] rise, nl, nv, tmp;
        logic         v, same;
        n++;
        pins.push_back(p);
        rise = '0;
        if (n >= 2) rise = vld[n-1] & vld[n-2] & lvl[n-1] & ~lvl[n-2];
        if (w && a == BASE + 16'd2) edge_m = edge_m & ~d[W-1:0];
        edge_m = edge_m | rise;
        if (w && a == BASE)         out_m  = d[W-1:0];
        if (w && a == BASE + 16'd3) mask_m = d[W-1:0];
        if (DB == 0) begin
            // Two-cycle delay: the level after edge n is the pin seen before edge n-1.
            nl = (n >= 2) ? pins[n-1] : '0;
            nv = (n >= 2) ? '1 : '0;
        end else begin
            // The level follows the pin once the last DB real samples agree.
            nl = lvl[n-1];
            nv = vld[n-1];
            if (n - DB >= 2) begin
                for (int b = 0; b < W; b++) begin
                    tmp  = pins[n-DB-1];
                    v    = tmp[b];
                    same = 1'b1;
                    for (int k = n - DB; k <= n - 1; k++) begin
                        tmp = pins[k-1];
                        if (tmp[b] !== v) same = 1'b0;
                    end
                    if (same) begin
                        nl[b] = v;
                        nv[b] = 1'b1;
                    end
                end
            end
        end
        lvl.push_back(nl);
        vld.push_back(nv);
    endtask

    // One bus cycle: drive at negedge, check rdata before the edge,
    // check registered outputs just after it.
    task automatic cycle(input logic w, input logic r, input logic [15:0] a,
                         input logic [15:0] d, input string tag,
                         input logic chk_c = 1'b0, input logic [15:0] c_exp = 16'h0);
        @(negedge clk);
        we = w; re = r; addr = a; wdata = d; gpio_in = cur_pin;
        #1;
        check({tag, ":rdata"}, rdata, r ? exp_read(a) : 16'h0000);
        if (r && chk_c) check({tag, ":const"}, rdata, c_exp);
        @(posedge clk);
        model_edge(w, a, d, cur_pin);
        #1;
        check({tag, ":gpio_out"}, 16'(gpio_out), 16'(out_m));
        check({tag, ":irq"}, 16'(irq), 16'(|(edge_m & mask_m)));
        we = 1'b0; re = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, 1'b0, 16'h0, 16'h0, "idle");
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cycle(1'b1, 1'b0, a, d, "wr");
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string tag);
        cycle(1'b0, 1'b1, a, 16'h0, tag, 1'b1, e);
    endtask

    // Assert reset between edges, check outputs drop at once, release after an edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ":gpio_out_now"}, 16'(gpio_out), 16'h0000);
        check({tag, ":irq_now"}, 16'(irq), 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic w, r;
        logic [15:0] a;
        int op;

        model_reset();
        #1 rst_n = 1'b0;
        #20;
        check("reset:gpio_out", 16'(gpio_out), 16'h0000);
        check("reset:irq", 16'(irq), 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        cur_pin = '0;
        idle(4);
        rd(BASE,     16'h0000, "reset_out");
        rd(BASE + 1, 16'h0000, "reset_in");
        rd(BASE + 2, 16'h0000, "reset_edge");
        rd(BASE + 3, 16'h0000, "reset_mask");

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: a short glitch is filtered, a long stable level passes.
        idle(12);
        cur_pin = 10'h002;
        idle(3);
        cur_pin = 10'h000;
        idle(12);
        rd(BASE + 1, 16'h0000, "db_glitch_in");
        rd(BASE + 2, 16'h0000, "db_glitch_edge");
        cur_pin = 10'h002;
        idle(10);
        rd(BASE + 1, 16'h0002, "db_stable_in");
        rd(BASE + 2, 16'h0002, "db_stable_edge");
        wr(BASE + 2, 16'h03FF);
`else
        // Output register write, then a write to the read-only IN register.
        wr(BASE, 16'h02A5);
        check("out_2a5", 16'(gpio_out), 16'h02A5);
        wr(BASE + 1, 16'hFFFF);
        rd(BASE,     16'h02A5, "in_wr_out");
        rd(BASE + 1, 16'h0000, "in_wr_in");
        rd(BASE + 2, 16'h0000, "in_wr_edge");
        rd(BASE + 3, 16'h0000, "in_wr_mask");

        // Input path latency and out-of-window read.
        cur_pin = 10'h155;
        idle(3);
        rd(BASE + 1, 16'h0155, "in_155");
        rd(BASE + 4, 16'h0000, "read_c004");
        rd(BASE + 2, 16'h0155, "edge_155");

        // Masked rising edge raises irq; W1C drops it.
        cur_pin = 10'h000;
        idle(4);
        wr(BASE + 2, 16'h03FF);
        rd(BASE + 2, 16'h0000, "edge_cleared");
        wr(BASE + 3, 16'h0001);
        cur_pin = 10'h001;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 16'h0, "irq_wait");
            if (irq) break;
        end
        check("irq_within_3", 16'(irq), 16'h0001);
        rd(BASE + 2, 16'h0001, "edge_bit0");
        wr(BASE + 2, 16'h0001);
        check("irq_after_w1c", 16'(irq), 16'h0000);

        // W1C on bit 3 in the very cycle its rising edge is recorded.
        cur_pin = 10'h009;
        idle(2);
        cycle(1'b1, 1'b1, BASE + 2, 16'h0008, "w1c_collide_pre", 1'b1, 16'h0000);
        rd(BASE + 2, 16'h0008, "w1c_collide_post");
        wr(BASE + 2, 16'h0008);
        rd(BASE + 2, 16'h0000, "w1c_bit3_clear");
`endif

        // Mid-run reset with OUT and irq active, inputs held high through release.
        cur_pin = 10'h000;
        idle(DB + 4);
        cur_pin = 10'h3FF;
        idle(DB + 4);
        wr(BASE + 3, 16'h03FF);
        wr(BASE, 16'h03FF);
        check("pre_reset_out", 16'(gpio_out), 16'h03FF);
        check("pre_reset_irq", 16'(irq), 16'h0001);
        async_reset("midrun");
        idle(DB + 8);
        rd(BASE + 2, 16'h0000, "held_high_edge");
        check("held_high_irq", 16'(irq), 16'h0000);
        rd(BASE + 1, 16'h03FF, "held_high_in");

        // Randomized traffic against the model.
        wr(BASE + 3, 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 5));
            w  = (op == 1) || (op == 2);
            r  = (op >= 2);
            if ($urandom_range(0, 9) == 0) a = 16'($urandom);
            else                            a = BASE + 16'($urandom_range(0, 5));
            if (DB == 0) begin
                if ($urandom_range(0, 2) == 0) cur_pin = W'($urandom);
            end else begin
                if ($urandom_range(0, 11) == 0) cur_pin = W'($urandom);
            end
            cycle(w, r, a, 16'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
